// File: rtl/soc_event_pkg.sv
// rtl/soc_event_pkg.sv - shared types, defaults and round-robin search for the event scheduler
//
// Purpose : FSM state type, defaults shared with the event generator, and the
//           wrap-around first-set-bit search used to pick the next winner.
// Ports   : none (package).

package soc_event_pkg;

   localparam int EVNT_NUM_DEF   = 34;
   localparam int EVNT_WIDTH_DEF = 8;
   localparam int SRCH_MAX       = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sched_state_t;

   typedef struct packed {
      logic       found;
      logic [5:0] idx;
   } rr_pick_t;

   // First set bit of req[n-1:0] at or after start, wrapping modulo n.
   // The loop runs from the farthest offset down to zero so the last hit
   // written is the closest one to start. start must be below n.
   function automatic rr_pick_t rr_search(input logic [63:0] req,
                                          input logic [5:0]  start,
                                          input logic [6:0]  n);
      rr_pick_t   pick;
      logic [7:0] k;
      pick = '0;
      for (int i = SRCH_MAX - 1; i >= 0; i--) begin
         k = {2'b00, start} + 8'(i);
         if (k >= {1'b0, n}) begin
            k = k - {1'b0, n};
         end
         if ((i < int'(n)) && req[k[5:0]]) begin
            pick.found = 1'b1;
            pick.idx   = k[5:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/soc_event_pend_cnt.sv
// rtl/soc_event_pend_cnt.sv - per-source saturating pending counter with overflow pulse
//
// Purpose : Buffers single-cycle event pulses for one source.
// Ports   : HCLK, HRESETn   clock, async active-low reset
//           inc             event pulse for this source
//           dec             this source's grant was accepted downstream
//           clr             synchronous clear, wins over inc/dec
//           nonzero         count != 0
//           gt1             count > 1 (still pending after one more accept)
//           err             one-cycle pulse: an event arrived at full count

module soc_event_pend_cnt #(
   parameter int CNT_WIDTH = 2
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic inc,
   input  logic dec,
   input  logic clr,
   output logic nonzero,
   output logic gt1,
   output logic err
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 inc_only;
   logic                 dec_only;

   // Simultaneous event and accept cancel out, so a full counter does not
   // overflow when it is being drained in the same cycle.
   assign inc_only = inc & ~dec;
   assign dec_only = dec & ~inc;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q <= '0;
         err   <= 1'b0;
      end else if (clr) begin
         cnt_q <= '0;
         err   <= 1'b0;
      end else begin
         err <= inc_only & (cnt_q == CNT_MAX);
         if (inc_only && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end else if (dec_only && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
         end
      end
   end

   assign nonzero = (cnt_q != '0);
   assign gt1     = (cnt_q > CNT_WIDTH'(1));

endmodule

// File: rtl/soc_event_rr_sched.sv
// rtl/soc_event_rr_sched.sv - round-robin scheduler onto the single SoC event bus
//
// Purpose : Buffers event pulses per source and presents one granted source
//           ID at a time on a valid/ready interface, round-robin fair.
// Ports   : HCLK, HRESETn   clock, async active-low reset
//           event_i         single-cycle event pulses, one bit per source
//           enable_i        per-source scheduling enable
//           clr_i           synchronous clear of all pending state
//           evt_valid_o     granted ID valid
//           evt_id_o        granted source index, zero-extended
//           evt_ready_i     downstream accepts the event
//           err_o           one-cycle overflow pulse per source
//           busy_o          any count pending or a grant outstanding

module soc_event_rr_sched
   import soc_event_pkg::*;
#(
   parameter int EVNT_NUM   = EVNT_NUM_DEF,
   parameter int CNT_WIDTH  = 2,
   parameter int EVNT_WIDTH = EVNT_WIDTH_DEF
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [EVNT_NUM-1:0]   event_i,
   input  logic [EVNT_NUM-1:0]   enable_i,
   input  logic                  clr_i,
   output logic                  evt_valid_o,
   output logic [EVNT_WIDTH-1:0] evt_id_o,
   input  logic                  evt_ready_i,
   output logic [EVNT_NUM-1:0]   err_o,
   output logic                  busy_o
);

   localparam int IDX_W = (EVNT_NUM > 1) ? $clog2(EVNT_NUM) : 1;

   sched_state_t        state_q;
   logic [IDX_W-1:0]    grant_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    ptr_nxt;
   logic [EVNT_NUM-1:0] nz;
   logic [EVNT_NUM-1:0] gt1;
   logic [EVNT_NUM-1:0] ack;
   logic [EVNT_NUM-1:0] req;
   logic [EVNT_NUM-1:0] req_hs;
   logic                handshake;
   rr_pick_t            pick_idle;
   rr_pick_t            pick_hs;

   assign handshake = evt_valid_o & evt_ready_i;

   genvar j;
   generate
      for (j = 0; j < EVNT_NUM; j++) begin : g_cnt
         assign ack[j] = handshake & (grant_q == IDX_W'(j));

         soc_event_pend_cnt #(
            .CNT_WIDTH (CNT_WIDTH)
         ) u_cnt (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .inc     (event_i[j]),
            .dec     (ack[j]),
            .clr     (clr_i),
            .nonzero (nz[j]),
            .gt1     (gt1[j]),
            .err     (err_o[j])
         );
      end
   endgenerate

   assign req = nz & enable_i;

   // On an accept the granted source's counter is about to drop by one, so
   // it only stays in contention if it holds more than one pending event.
   always_comb begin
      req_hs          = req;
      req_hs[grant_q] = gt1[grant_q] & enable_i[grant_q];
   end

   assign ptr_nxt = (grant_q == IDX_W'(EVNT_NUM - 1)) ? '0 : grant_q + IDX_W'(1);

   assign pick_idle = rr_search(64'(req),    6'(ptr_q),   7'(EVNT_NUM));
   assign pick_hs   = rr_search(64'(req_hs), 6'(ptr_nxt), 7'(EVNT_NUM));

   // A grant is held until accepted; enable_i is only consulted when
   // choosing the next winner, never to withdraw the current one.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         ptr_q       <= '0;
         evt_valid_o <= 1'b0;
         evt_id_o    <= '0;
      end else if (clr_i) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         ptr_q       <= '0;
         evt_valid_o <= 1'b0;
         evt_id_o    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_idle.found) begin
                  state_q     <= GRANT;
                  grant_q     <= IDX_W'(pick_idle.idx);
                  evt_valid_o <= 1'b1;
                  evt_id_o    <= EVNT_WIDTH'(pick_idle.idx);
               end
            end
            GRANT: begin
               if (evt_ready_i) begin
                  ptr_q <= ptr_nxt;
                  if (pick_hs.found) begin
                     grant_q  <= IDX_W'(pick_hs.idx);
                     evt_id_o <= EVNT_WIDTH'(pick_hs.idx);
                  end else begin
                     state_q     <= IDLE;
                     evt_valid_o <= 1'b0;
                     evt_id_o    <= '0;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               evt_valid_o <= 1'b0;
               evt_id_o    <= '0;
            end
         endcase
      end
   end

   assign busy_o = (|nz) | evt_valid_o;

endmodule

// File: tb/tb_soc_event_rr_sched.sv
// tb/tb_soc_event_rr_sched.sv - scoreboard bench for the round-robin event scheduler

module tb_soc_event_rr_sched;

   localparam int N = 34;
   localparam int W = 8;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic [N-1:0]  event_i;
   logic [N-1:0]  enable_i;
   logic          clr_i;
   logic          evt_valid_o;
   logic [W-1:0]  evt_id_o;
   logic          evt_ready_i;
   logic [N-1:0]  err_o;
   logic          busy_o;

   int            n_cmp  = 0;
   int            n_fail = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  mon_exp;
   bit            mon_en = 1'b0;

   soc_event_rr_sched #(
      .EVNT_NUM   (N),
      .CNT_WIDTH  (2),
      .EVNT_WIDTH (W)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .event_i     (event_i),
      .enable_i    (enable_i),
      .clr_i       (clr_i),
      .evt_valid_o (evt_valid_o),
      .evt_id_o    (evt_id_o),
      .evt_ready_i (evt_ready_i),
      .err_o       (err_o),
      .busy_o      (busy_o)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted grant is popped against the scoreboard.
   always @(negedge HCLK) begin
      if (mon_en && evt_valid_o && evt_ready_i) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_grant: got id %0d expected none", evt_id_o);
         end else begin
            mon_exp = exp_q.pop_front();
            check("grant_id", 64'(evt_id_o), 64'(mon_exp));
         end
      end
   end

   function automatic logic [N-1:0] bitm(input int i);
      logic [N-1:0] m;
      m    = '0;
      m[i] = 1'b1;
      return m;
   endfunction

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic pulse(input logic [N-1:0] m);
      event_i = m;
      tick();
      event_i = '0;
   endtask

   task automatic do_clr(input logic [N-1:0] m);
      clr_i   = 1'b1;
      event_i = m;
      tick();
      clr_i   = 1'b0;
      event_i = '0;
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || busy_o) && c < 60) begin
         tick();
         c++;
      end
      check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
      check({name, "_busy_low"}, 64'(busy_o), 64'(0));
   endtask

   initial begin
      HRESETn     = 1'b0;
      event_i     = '0;
      enable_i    = '1;
      clr_i       = 1'b0;
      evt_ready_i = 1'b1;
      repeat (3) tick();
      check("rst_valid", 64'(evt_valid_o), 64'(0));
      check("rst_id",    64'(evt_id_o),    64'(0));
      check("rst_err",   64'(err_o),       64'(0));
      check("rst_busy",  64'(busy_o),      64'(0));
      HRESETn = 1'b1;
      tick();
      mon_en = 1'b1;

      // Single event on source 5: valid exactly at t+2.
      exp_q.push_back(8'd5);
      pulse(bitm(5));
      check("t1_valid_t1", 64'(evt_valid_o), 64'(0));
      check("t1_busy_t1",  64'(busy_o),      64'(1));
      tick();
      check("t1_valid_t2", 64'(evt_valid_o), 64'(1));
      check("t1_id_t2",    64'(evt_id_o),    64'(5));
      tick();
      check("t1_valid_t3", 64'(evt_valid_o), 64'(0));
      check("t1_busy_t3",  64'(busy_o),      64'(0));

      // Three sources at once from ptr 0, back to back.
      do_clr('0);
      exp_q.push_back(8'd3);
      exp_q.push_back(8'd7);
      exp_q.push_back(8'd20);
      pulse(bitm(3) | bitm(7) | bitm(20));
      tick();
      for (int k = 0; k < 3; k++) begin
         check("t2_b2b_valid", 64'(evt_valid_o), 64'(1));
         tick();
      end
      check("t2_idle_after", 64'(evt_valid_o), 64'(0));
      // ptr is now 21: 22 must win over 2.
      exp_q.push_back(8'd22);
      exp_q.push_back(8'd2);
      pulse(bitm(2) | bitm(22));
      drain("t2");

      // Overflow on source 2 with ready low.
      do_clr('0);
      evt_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         event_i = bitm(2);
         tick();
         check("t3_err", 64'(err_o), (k == 3) ? 64'(bitm(2)) : 64'(0));
      end
      event_i = '0;
      tick();
      check("t3_err_gone", 64'(err_o), 64'(0));
      check("t3_held_id",  64'(evt_id_o), 64'(2));
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd2);
      evt_ready_i = 1'b1;
      drain("t3");

      // Grant held while enable drops; not re-granted while disabled.
      do_clr('0);
      evt_ready_i = 1'b0;
      pulse(bitm(9));
      pulse(bitm(9));
      enable_i[9] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("t4_hold_valid", 64'(evt_valid_o), 64'(1));
         check("t4_hold_id",    64'(evt_id_o),    64'(9));
         tick();
      end
      exp_q.push_back(8'd9);
      evt_ready_i = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         check("t4_no_regrant", 64'(evt_valid_o), 64'(0));
         tick();
      end
      enable_i[9] = 1'b1;
      exp_q.push_back(8'd9);
      drain("t4");

      // Source 4 pulsing for six cycles while 30 has one pending.
      do_clr('0);
      exp_q.push_back(8'd4);
      exp_q.push_back(8'd30);
      for (int k = 0; k < 5; k++) exp_q.push_back(8'd4);
      event_i = bitm(4) | bitm(30);
      tick();
      event_i = bitm(4);
      for (int k = 0; k < 5; k++) begin
         check("t5_no_err", 64'(err_o), 64'(0));
         tick();
      end
      event_i = '0;
      drain("t5");

      // Clear while granting; same-cycle event 15 is discarded.
      evt_ready_i = 1'b0;
      pulse(bitm(10) | bitm(11) | bitm(12));
      tick();
      check("t6_pre_id", 64'(evt_id_o), 64'(10));
      do_clr(bitm(15));
      check("t6_clr_valid", 64'(evt_valid_o), 64'(0));
      check("t6_clr_busy",  64'(busy_o),      64'(0));
      evt_ready_i = 1'b1;
      exp_q.push_back(8'd1);
      pulse(bitm(1));
      drain("t6");

      // Reset while a grant is outstanding.
      evt_ready_i = 1'b0;
      pulse(bitm(6));
      tick();
      check("t7_pre_valid", 64'(evt_valid_o), 64'(1));
      HRESETn     = 1'b0;
      evt_ready_i = 1'b1;
      #1;
      check("t7_rst_valid", 64'(evt_valid_o), 64'(0));
      check("t7_rst_busy",  64'(busy_o),      64'(0));
      tick();
      HRESETn = 1'b1;
      tick();
      tick();
      check("t7_after_busy", 64'(busy_o), 64'(0));

      check("final_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
